mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline; sits between EXE and WB.
//  - Waits for the data-SRAM response (req/addr_ok/data_ok protocol) on loads and stores.
//  - Extracts and extends load data, and computes the byte write strobe.
//  - Builds the MS->WS bus that WB consumes; drops in-flight responses after an exception or ERET flush.

---
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: waits on data-SRAM responses, extracts load data, feeds WB.
// Build option: define MS_UNALIGNED_LOAD_EN to enable lwl/lwr merge data and strobes.
module mem_stage #(
  parameter int ES_TO_MS_WD = 87,
  parameter int MS_TO_WS_WD = 79
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   ms_allowin,
  input  logic                   ws_allowin,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   ws_ex,
  input  logic                   eret_flush,
  output logic                   ms_ex_o,
  output logic                   ms_fwd_valid,
  output logic [4:0]             ms_fwd_dest,
  output logic [31:0]            ms_fwd_data,
  output logic                   ms_inst_mfc0_o
);

  typedef struct packed {
    logic        mem_req;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [6:0]  ld_op;     // {lwr,lwl,lhu,lh,lbu,lb,lw}
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ws_bus_t;

  es_bus_t     es_in;
  es_bus_t     bus_q;
  ws_bus_t     ws_out;
  logic        ms_valid_q;
  logic        rbuf_valid_q;
  logic [31:0] rbuf_q;
  logic [1:0]  cancel_cnt_q, cancel_cnt_d;

  logic        flush;
  logic        data_ok_live;
  logic        ms_ready_go;
  logic        handoff;
  logic        rbuf_load;

  assign es_in = es_bus_t'(es_to_ms_bus);
  assign flush = ws_ex | eret_flush;

  // A beat only belongs to the current instruction once every cancelled request has drained.
  assign data_ok_live   = data_sram_data_ok & (cancel_cnt_q == 2'd0);
  assign ms_ready_go    = !bus_q.mem_req | rbuf_valid_q | data_ok_live;
  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & !flush;
  assign handoff        = ms_to_ws_valid & ws_allowin;
  assign rbuf_load      = ms_valid_q & bus_q.mem_req & !rbuf_valid_q & data_ok_live & !ws_allowin;

  // Load data extraction
  logic [31:0] ld_src;
  logic [1:0]  lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        is_ld;
  logic [31:0] final_result;
  logic [3:0]  final_strb;

  assign ld_src  = rbuf_valid_q ? rbuf_q : data_sram_rdata;
  assign lo      = bus_q.alu_res[1:0];
  assign ld_byte = ld_src[{lo, 3'b000} +: 8];
  assign ld_half = ld_src[{lo[1], 4'b0000} +: 16];
  assign is_ld   = |bus_q.ld_op[4:0];

  always_comb begin
    final_result = bus_q.alu_res;
    final_strb   = bus_q.gr_strb;
    if (is_ld) begin
      final_strb = (|bus_q.gr_strb) ? 4'b1111 : 4'b0000;
      if (bus_q.ld_op[1])      final_result = {{24{ld_byte[7]}}, ld_byte};
      else if (bus_q.ld_op[2]) final_result = {24'd0, ld_byte};
      else if (bus_q.ld_op[3]) final_result = {{16{ld_half[15]}}, ld_half};
      else if (bus_q.ld_op[4]) final_result = {16'd0, ld_half};
      else                     final_result = ld_src;
    end
`ifdef MS_UNALIGNED_LOAD_EN
    else if (bus_q.ld_op[5]) begin
      // lwl: 8*(3-lo) == {~lo,3'b000}
      final_result = ld_src << {~lo, 3'b000};
      final_strb   = 4'b1111 << ~lo;
    end else if (bus_q.ld_op[6]) begin
      final_result = ld_src >> {lo, 3'b000};
      final_strb   = 4'b1111 >> lo;
    end
`else
    else if (|bus_q.ld_op[6:5]) begin
      final_result = ld_src;
      final_strb   = 4'b0000;
    end
`endif
  end

  always_comb begin
    ws_out.ex           = bus_q.ex;
    ws_out.bd           = bus_q.bd;
    ws_out.eret         = bus_q.eret;
    ws_out.syscall      = bus_q.syscall;
    ws_out.mfc0         = bus_q.mfc0;
    ws_out.mtc0         = bus_q.mtc0;
    ws_out.gr_strb      = final_strb;
    ws_out.dest         = bus_q.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = bus_q.pc;
  end

  assign ms_to_ws_bus   = ws_out;
  assign ms_ex_o        = ms_valid_q & bus_q.ex;
  assign ms_fwd_valid   = ms_valid_q & (|final_strb) & ms_ready_go;
  assign ms_fwd_dest    = ms_valid_q ? bus_q.dest : 5'd0;
  assign ms_fwd_data    = final_result;
  assign ms_inst_mfc0_o = ms_valid_q & bus_q.mfc0;

  // Outstanding requests orphaned by a flush; their beats must be swallowed in order.
  logic       cancel_ms;
  logic       cancel_es;
  logic       cancel_dec;
  logic [2:0] cancel_sum;

  assign cancel_ms  = flush & ms_valid_q & bus_q.mem_req & !rbuf_valid_q & !data_sram_data_ok;
  assign cancel_es  = flush & es_to_ms_valid & es_in.mem_req;
  assign cancel_dec = data_sram_data_ok & (cancel_cnt_q != 2'd0);

  always_comb begin
    cancel_sum   = {1'b0, cancel_cnt_q} + {2'b00, cancel_ms} + {2'b00, cancel_es}
                 - {2'b00, cancel_dec};
    cancel_cnt_d = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= 32'd0;
      cancel_cnt_q <= 2'd0;
      bus_q        <= '0;
    end else begin
      cancel_cnt_q <= cancel_cnt_d;

      if (flush)           ms_valid_q <= 1'b0;
      else if (ms_allowin) ms_valid_q <= es_to_ms_valid;

      if (ms_allowin && es_to_ms_valid) bus_q <= es_in;

      if (flush) begin
        rbuf_valid_q <= 1'b0;
      end else if (rbuf_load) begin
        rbuf_valid_q <= 1'b1;
        rbuf_q       <= data_sram_rdata;
      end else if (handoff) begin
        rbuf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: handshake, response buffer, flush cancellation, load extraction.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic [86:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [78:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_ex;
  logic        eret_flush;
  logic        ms_ex_o;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_inst_mfc0_o;

  int checks = 0;
  int passes = 0;

  localparam logic [6:0] LW = 7'b0000001, LB = 7'b0000010, LHU = 7'b0010000,
                         LWL = 7'b0100000, LWR = 7'b1000000, NOLD = 7'b0000000;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_ex(ws_ex), .eret_flush(eret_flush),
    .ms_ex_o(ms_ex_o), .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
    .ms_fwd_data(ms_fwd_data), .ms_inst_mfc0_o(ms_inst_mfc0_o)
  );

  always #5 clk = ~clk;

  function automatic logic [86:0] mk(input logic mem_req, input logic ex, input logic mfc0,
                                     input logic [6:0] ld_op, input logic [3:0] strb,
                                     input logic [4:0] dest, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {mem_req, ex, 1'b0, 1'b0, 1'b0, mfc0, 1'b0, ld_op, strb, dest, alu, pc};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 1, 0, LW, 4'hf, 5'd3, 32'h0, 32'h0);
    ws_allowin = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    ws_ex = 1'b0; eret_flush = 1'b0;
    tick; tick;
    es_to_ms_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b1) $display("FAIL reset_allowin got %b want 1", ms_allowin); else passes++;
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ms_to_ws_valid); else passes++;
    checks++; if (ms_ex_o !== 1'b0) $display("FAIL reset_ex got %b want 0", ms_ex_o); else passes++;
    checks++; if (ms_fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid got %b want 0", ms_fwd_valid); else passes++;
    checks++; if (ms_fwd_dest !== 5'd0) $display("FAIL reset_fwd_dest got %0d want 0", ms_fwd_dest); else passes++;
  endtask

  task automatic test_lb;
    tick;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LB, 4'hf, 5'd5, 32'h0000_1003, 32'h100);
    tick;
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8011_2233;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL lb_valid got %b want 1", ms_to_ws_valid); else passes++;
    checks++; if (ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) $display("FAIL lb_data got %h want ffffff80", ms_to_ws_bus[63:32]); else passes++;
    checks++; if (ms_to_ws_bus[72:69] !== 4'b1111) $display("FAIL lb_strb got %b want 1111", ms_to_ws_bus[72:69]); else passes++;
    checks++; if (ms_fwd_valid !== 1'b1 || ms_fwd_dest !== 5'd5) $display("FAIL lb_fwd got %b/%0d want 1/5", ms_fwd_valid, ms_fwd_dest); else passes++;
    tick;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) $display("FAIL lb_one_cycle got %b/%b want 0/1", ms_to_ws_valid, ms_allowin); else passes++;
  endtask

  task automatic test_rbuf;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LHU, 4'hf, 5'd6, 32'h0000_2002, 32'h200);
    tick;
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0000;
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b0) $display("FAIL rbuf_stall got %b want 0", ms_allowin); else passes++;
    tick;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_DEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_BEEF)
        $display("FAIL rbuf_hold%0d got %b/%h want 1/0000beef", i, ms_to_ws_valid, ms_to_ws_bus[63:32]); else passes++;
      tick;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_BEEF)
      $display("FAIL rbuf_handoff got %b/%h want 1/0000beef", ms_to_ws_valid, ms_to_ws_bus[63:32]); else passes++;
    tick;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL rbuf_after got %b want 0", ms_to_ws_valid); else passes++;
  endtask

  task automatic test_flush_cancel;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd7, 32'h0000_3000, 32'h300);
    tick;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) $display("FAIL cancel_wait got %b/%b want 0/0", ms_to_ws_valid, ms_allowin); else passes++;
    tick;
    ws_ex = 1'b1;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL cancel_flush_cycle got %b want 0", ms_to_ws_valid); else passes++;
    tick;
    ws_ex = 1'b0;
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b1 || ms_fwd_dest !== 5'd0) $display("FAIL cancel_idle got %b/%0d want 1/0", ms_allowin, ms_fwd_dest); else passes++;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd8, 32'h0000_3004, 32'h304);
    tick;
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL cancel_drop got %b want 0", ms_to_ws_valid); else passes++;
    tick;
    data_sram_rdata = 32'h2222_2222;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h2222_2222)
      $display("FAIL cancel_deliver got %b/%h want 1/22222222", ms_to_ws_valid, ms_to_ws_bus[63:32]); else passes++;
    tick;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_double_cancel;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd9, 32'h0000_4000, 32'h400);
    tick;
    es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd10, 32'h0000_4004, 32'h404);
    eret_flush = 1'b1;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL dcancel_flush_cycle got %b want 0", ms_to_ws_valid); else passes++;
    tick;
    eret_flush = 1'b0; es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) $display("FAIL dcancel_idle got %b/%b want 1/0", ms_allowin, ms_to_ws_valid); else passes++;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd11, 32'h0000_4008, 32'h408);
    tick;
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0001;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL dcancel_drop1 got %b want 0", ms_to_ws_valid); else passes++;
    tick;
    data_sram_rdata = 32'hAAAA_0002;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL dcancel_drop2 got %b want 0", ms_to_ws_valid); else passes++;
    tick;
    data_sram_rdata = 32'hAAAA_0003;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hAAAA_0003)
      $display("FAIL dcancel_deliver got %b/%h want 1/aaaa0003", ms_to_ws_valid, ms_to_ws_bus[63:32]); else passes++;
    tick;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_unaligned;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LWL, 4'hf, 5'd12, 32'h0000_5001, 32'h500);
    tick;
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD;
    @(negedge clk);
`ifdef MS_UNALIGNED_LOAD_EN
    checks++; if (ms_to_ws_bus[63:32] !== 32'hCCDD_0000) $display("FAIL lwl_data got %h want ccdd0000", ms_to_ws_bus[63:32]); else passes++;
    checks++; if (ms_to_ws_bus[72:69] !== 4'b1100) $display("FAIL lwl_strb got %b want 1100", ms_to_ws_bus[72:69]); else passes++;
`else
    checks++; if (ms_to_ws_bus[72:69] !== 4'b0000) $display("FAIL lwl_strb got %b want 0000", ms_to_ws_bus[72:69]); else passes++;
    checks++; if (ms_fwd_valid !== 1'b0) $display("FAIL lwl_fwd got %b want 0", ms_fwd_valid); else passes++;
`endif
    tick;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LWR, 4'hf, 5'd13, 32'h0000_5001, 32'h504);
    data_sram_data_ok = 1'b0;
    tick;
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1;
    @(negedge clk);
`ifdef MS_UNALIGNED_LOAD_EN
    checks++; if (ms_to_ws_bus[63:32] !== 32'h00AA_BBCC || ms_to_ws_bus[72:69] !== 4'b0111)
      $display("FAIL lwr got %h/%b want 00aabbcc/0111", ms_to_ws_bus[63:32], ms_to_ws_bus[72:69]); else passes++;
`else
    checks++; if (ms_to_ws_bus[63:32] !== 32'hAABB_CCDD || ms_to_ws_bus[72:69] !== 4'b0000)
      $display("FAIL lwr got %h/%b want aabbccdd/0000", ms_to_ws_bus[63:32], ms_to_ws_bus[72:69]); else passes++;
`endif
    tick;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(0, 1, 0, NOLD, 4'h0, 5'd0, 32'hBFC0_0380, 32'h600);
    tick;
    es_to_ms_bus = mk(0, 0, 0, NOLD, 4'b0110, 5'd14, 32'h1234_5678, 32'h604);
    @(negedge clk);
    checks++; if (ms_ex_o !== 1'b1 || ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[78] !== 1'b1)
      $display("FAIL ex_pass got %b/%b/%b want 1/1/1", ms_ex_o, ms_to_ws_valid, ms_to_ws_bus[78]); else passes++;
    tick;
    es_to_ms_bus = mk(0, 0, 1, NOLD, 4'hf, 5'd15, 32'h0000_00C0, 32'h608);
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1234_5678 || ms_to_ws_bus[72:69] !== 4'b0110)
      $display("FAIL addu got %b/%h/%b want 1/12345678/0110", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[72:69]); else passes++;
    checks++; if (ms_ex_o !== 1'b0 || ms_fwd_dest !== 5'd14) $display("FAIL addu_side got %b/%0d want 0/14", ms_ex_o, ms_fwd_dest); else passes++;
    tick;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (ms_inst_mfc0_o !== 1'b1 || ms_to_ws_bus[74] !== 1'b1) $display("FAIL mfc0 got %b/%b want 1/1", ms_inst_mfc0_o, ms_to_ws_bus[74]); else passes++;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd16, 32'h0000_7000, 32'h700);
    tick;
    es_to_ms_valid = 1'b0; ws_ex = 1'b1;
    tick;
    ws_ex = 1'b0;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd17, 32'h0000_7004, 32'h704);
    tick;
    es_to_ms_valid = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) $display("FAIL rst_mid got %b/%b want 1/0", ms_allowin, ms_to_ws_valid); else passes++;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1, 0, 0, LW, 4'hf, 5'd18, 32'h0000_7008, 32'h708);
    tick;
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A_1234;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h5A5A_1234)
      $display("FAIL rst_cancel_clear got %b/%h want 1/5a5a1234", ms_to_ws_valid, ms_to_ws_bus[63:32]); else passes++;
    tick;
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    test_reset;
    test_lb;
    test_rbuf;
    test_flush_cancel;
    test_double_cancel;
    test_unaligned;
    test_back_to_back;
    test_reset_mid_wait;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
